// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keypad decoder.
//   - scancode constants (prefixes, mapped keys, overflow codes)
//   - SNES button bit positions within key_mux
//   - receiver and decoder state enums
//   - key_lookup(): scancode + extended context -> button index
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_B      = 8'h22;
    localparam logic [7:0] SC_Y      = 8'h1A;
    localparam logic [7:0] SC_SELECT = 8'h59;
    localparam logic [7:0] SC_START  = 8'h5A;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_OVF0   = 8'h00;
    localparam logic [7:0] SC_OVF1   = 8'hFF;

    localparam logic [2:0] BTN_B      = 3'd0;
    localparam logic [2:0] BTN_Y      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_lookup_t;

    // The arrow keys share codes with the keypad; only the E0-prefixed
    // form is an arrow, the bare form is the keypad and stays unmapped.
    function automatic key_lookup_t key_lookup(input logic [7:0] code, input logic ext);
        key_lookup_t r;
        r = '0;
        if (ext) begin
            case (code)
                SC_UP:    r = '{hit: 1'b1, idx: BTN_UP};
                SC_DOWN:  r = '{hit: 1'b1, idx: BTN_DOWN};
                SC_LEFT:  r = '{hit: 1'b1, idx: BTN_LEFT};
                SC_RIGHT: r = '{hit: 1'b1, idx: BTN_RIGHT};
                default:  r = '0;
            endcase
        end else begin
            case (code)
                SC_B:      r = '{hit: 1'b1, idx: BTN_B};
                SC_Y:      r = '{hit: 1'b1, idx: BTN_Y};
                SC_SELECT: r = '{hit: 1'b1, idx: BTN_SELECT};
                SC_START:  r = '{hit: 1'b1, idx: BTN_START};
                default:   r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_keypad_decoder_if.sv
// PS/2 keypad decoder bus: serial PS/2 lines in, frame/debug/button outputs.
//   kb_clk_serial, kb_in_serial : PS/2 clock and data lines (async to clk)
//   kb_data                     : last good 11-bit frame
//   frame_valid, frame_err      : 1-cycle frame status strobes
//   key_mux                     : active-high SNES button mask
// master = line driver / result consumer, slave = the decoder.
interface ps2_keypad_decoder_if;
    logic        kb_clk_serial;
    logic        kb_in_serial;
    logic [10:0] kb_data;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  key_mux;

    modport master (
        output kb_clk_serial, kb_in_serial,
        input  kb_data, frame_valid, frame_err, key_mux
    );

    modport slave (
        input  kb_clk_serial, kb_in_serial,
        output kb_data, frame_valid, frame_err, key_mux
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, 11-bit
// frame assembly with start/stop/odd-parity check and a mid-frame timeout.
//   clk, reset_n          : system clock, async active-low reset
//   kb_clk_serial         : PS/2 clock line (async)
//   kb_in_serial          : PS/2 data line (async)
//   kb_data               : last good frame, held on errors
//   frame_valid/frame_err : 1-cycle strobes, the cycle after the 11th fall
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        kb_clk_serial,
    input  logic        kb_in_serial,
    output logic [10:0] kb_data,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYCLES - 1);

    logic [1:0]  clk_sync_q;
    logic [1:0]  dat_sync_q;
    logic        clk_prev_q;
    logic        fall_q;

    rx_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  shift_q, shift_d;
    logic [12:0] tmo_q, tmo_d;
    logic [10:0] kb_data_q, kb_data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [10:0] frame_w;
    logic        frame_ok;

    // Sync flops reset to the idle-high line level so a reset release
    // with the line high cannot fake a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], kb_clk_serial};
            dat_sync_q <= {dat_sync_q[0], kb_in_serial};
            clk_prev_q <= clk_sync_q[1];
            fall_q     <= clk_prev_q & ~clk_sync_q[1];
        end
    end

    // Bits arrive LSB first and enter at the top, so after the 11th bit
    // the start bit has walked down to [0].
    assign frame_w  = {dat_sync_q[1], shift_q};
    assign frame_ok = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        kb_data_d = kb_data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                tmo_d = '0;
                if (fall_q) begin
                    shift_d = {dat_sync_q[1], 9'b0};
                    cnt_d   = 4'd1;
                    state_d = RX_RECV;
                end
            end
            RX_RECV: begin
                if (fall_q) begin
                    tmo_d   = '0;
                    shift_d = frame_w[10:1];
                    if (cnt_q == 4'd10) begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                        if (frame_ok) begin
                            valid_d   = 1'b1;
                            kb_data_d = frame_w;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 13'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            kb_data_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            kb_data_q <= kb_data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign kb_data     = kb_data_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keyboard to SNES button mask. Receives frames through ps2_rx and
// tracks E0/F0 prefixes to set (make) or clear (break) button bits.
//   clk, reset_n : system clock (2.08 MHz), async active-low reset
//   bus (slave)  : PS/2 lines in; kb_data, frame_valid, frame_err, key_mux out
//
// state       | meaning
// DEC_BASE    | no prefix pending
// DEC_EXT     | E0 seen, next code is extended
// DEC_BRK     | F0 seen, next code is a release
// DEC_EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_keypad_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4160
) (
    input logic                  clk,
    input logic                  reset_n,
    ps2_keypad_decoder_if.slave  bus
);

    logic [10:0] kb_data_w;
    logic        frame_valid_w;
    logic        frame_err_w;

    dec_state_t  state_q, state_d;
    logic [7:0]  key_q, key_d;

    logic [7:0]  code_w;
    logic        ext_w;
    logic        brk_w;
    key_lookup_t lk_w;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk           (clk),
        .reset_n       (reset_n),
        .kb_clk_serial (bus.kb_clk_serial),
        .kb_in_serial  (bus.kb_in_serial),
        .kb_data       (kb_data_w),
        .frame_valid   (frame_valid_w),
        .frame_err     (frame_err_w)
    );

    assign code_w = kb_data_w[8:1];
    assign ext_w  = (state_q == DEC_EXT) || (state_q == DEC_EXT_BRK);
    assign brk_w  = (state_q == DEC_BRK) || (state_q == DEC_EXT_BRK);
    assign lk_w   = key_lookup(code_w, ext_w);

    // A prefix byte arriving after F0 is not a legal sequence; it falls
    // through to the lookup, misses, and resynchronises to BASE.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        if (frame_err_w) begin
            state_d = DEC_BASE;
        end else if (frame_valid_w) begin
            state_d = DEC_BASE;
            if (code_w == SC_OVF0 || code_w == SC_OVF1) begin
                key_d = '0;
            end else if (code_w == SC_EXT && !brk_w) begin
                state_d = DEC_EXT;
            end else if (code_w == SC_BRK && !brk_w) begin
                state_d = ext_w ? DEC_EXT_BRK : DEC_BRK;
            end else if (lk_w.hit) begin
                key_d[lk_w.idx] = ~brk_w;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DEC_BASE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    assign bus.kb_data     = kb_data_w;
    assign bus.frame_valid = frame_valid_w;
    assign bus.frame_err   = frame_err_w;
    assign bus.key_mux     = key_q;

endmodule

// File: doc/ps2_keypad_decoder.md
# ps2_keypad_decoder

Receives the PS/2 keyboard serial stream and decodes make/break scancodes into an 8-bit, active-high SNES button mask. It sits directly upstream of `multiplexer` and drives its `key_mux` input. It also exports the raw 11-bit frame as `kb_data` for debug. It runs on the design's 2.08 MHz system clock.

## Interface
- `TIMEOUT_CYCLES`, default 4160: idle clocks (about 2 ms) allowed mid-frame before the partial frame is discarded.
- `clk` input 1: system clock, 2.08 MHz.
- `reset_n` input 1: asynchronous, active-low reset.
- `kb_clk_serial` input 1: PS/2 clock line, asynchronous to `clk`.
- `kb_in_serial` input 1: PS/2 data line, asynchronous to `clk`.
- `kb_data` output 11: last complete frame. [0]=start, [8:1]=data (LSB = first bit received), [9]=parity, [10]=stop.
- `frame_valid` output 1: 1-cycle strobe. Good frame received; `kb_data` updated in the same cycle.
- `frame_err` output 1: 1-cycle strobe. Frame dropped because of bad start, bad stop, bad parity or timeout.
- `key_mux` output 8: pressed mask, bit=1 when pressed. Bit map: [0]=B, [1]=Y, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.

## Operation
- Synchronisation:
  - `kb_clk_serial` and `kb_in_serial` each pass through a 2-flop synchroniser.
  - A falling edge of the synchronised clock produces a 1-cycle `fall` pulse.
- Receiver FSM:
  - States are IDLE and RECV. A 4-bit bit counter runs 0–10. A 13-bit timeout counter is cleared on every `fall`.
  - IDLE: on `fall`, sample data as bit 0 and go to RECV with the counter at 1.
  - RECV: on each `fall`, shift in the data bit and increment the counter.
  - When bit 10 is taken, return to IDLE and check the frame. The frame is good when start=0, stop=1, and the XOR of data and parity is 1 (odd parity).
    - Good frame: pulse `frame_valid` and load `kb_data`.
    - Bad frame: pulse `frame_err`; `kb_data` is held.
  - RECV with no `fall` for `TIMEOUT_CYCLES` consecutive clocks: pulse `frame_err`, go to IDLE, counter to 0.
- Decoder FSM:
  - States are BASE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Decoder input is the data byte, consumed on `frame_valid`.
  - E0 from BASE goes to EXT. F0 from BASE goes to BRK. F0 from EXT goes to EXT_BRK.
  - Any other byte is looked up using the current extended/break context, sets the mapped bit (make) or clears it (break), then the FSM returns to BASE.
  - Unmapped codes change nothing and return to BASE. E0 received in EXT stays in EXT.
- Key map:
  - Non-extended: 0x22 (X)→B, 0x1A (Z)→Y, 0x59 (R-Shift)→Select, 0x5A (Enter)→Start.
  - Extended: 0x75→Up, 0x72→Down, 0x6B→Left, 0x74→Right.
  - Non-extended codes 0x75, 0x72, 0x6B and 0x74 (keypad) are unmapped.
- Overflow codes 0x00 and 0xFF force `key_mux` to 0 and return the decoder to BASE.
- A `frame_err` returns the decoder to BASE; `key_mux` is held.
- A break for a key not pressed is a no-op, as is a repeated make (typematic).

## Timing
- Reset values: `kb_data`=0, `frame_valid`=0, `frame_err`=0, `key_mux`=0. Both FSMs go to IDLE/BASE and all counters go to 0.
- Reset mid-frame abandons the partial frame; no strobe is issued.
- Line to `fall`: 3 clocks from the pin transition (2 synchroniser flops plus the edge register).
- `frame_valid` and `frame_err` are asserted the cycle after the 11th `fall`.
- `key_mux` updates the cycle after `frame_valid`. Total latency from 11th pin edge to `key_mux` is 5 clocks.
- A new `fall` is never co-incident with a strobe, because PS/2 bit periods are at least 120 clocks. No back-pressure exists; every frame is consumed.
- The timeout counter saturates and compares with `== TIMEOUT_CYCLES-1`.

## Structure
- Package `ps2_pkg` holds:
  - scancode constants: `SC_EXT`=0xE0, `SC_BRK`=0xF0, the eight key codes, and `SC_OVF0`/`SC_OVF1`;
  - button bit index constants;
  - `rx_state_t` and `dec_state_t` enums.
- Sub-module `ps2_rx` contains the synchronisers, the receiver FSM and the timeout. It outputs `kb_data`, `frame_valid` and `frame_err`.
- `ps2_keypad_decoder` instantiates `ps2_rx` and contains the decoder FSM and the `key_mux` register.

## Test plan
- Reset, then send frame 0x22 (parity=1, `kb_data`=0x644) → `frame_valid` pulses, and `key_mux`=0x01 5 clocks after the 11th edge.
- Send 0x22, then F0 22 → `key_mux` goes 0x01 then 0x00. Send E0 75 then E0 F0 75 → 0x10 then 0x00. Send non-extended 75 → 0x00.
- Press 5A and E0 74, then send FF → `key_mux` goes 0x88, then 0x00.
- Send frame 0x1A with parity bit flipped → `frame_err` pulses; `key_mux` and `kb_data` are unchanged. A following good 0x1A gives 0x02.
- Send 5 bits and stall for 4160 clocks → one `frame_err` and the receiver is in IDLE. A following 0x59 frame gives `key_mux`=0x04.
- Assert `reset_n` low after bit 6 of a frame → all outputs are 0 immediately and no strobe is issued. A clean 0x5A frame after release gives 0x08.
